// File: rtl/tx_arb_pkg.sv
// Shared constants, types and the round-robin helper for the TX channel arbiter.
package tx_arb_pkg;

  // Fixed source encoding on the merged transaction-layer TX path.
  localparam logic [2:0] CH_BARRIER = 3'd0;
  localparam logic [2:0] CH_B       = 3'd1;
  localparam logic [2:0] CH_R       = 3'd2;
  localparam logic [2:0] CH_AR      = 3'd3;
  localparam logic [2:0] CH_AW      = 3'd4;
  localparam logic [2:0] GRANT_NONE = 3'd7;

  // Sideband field widths carried with every beat.
  localparam int CONN_ID_W  = 4;
  localparam int BYTE_NUM_W = 13;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // First requesting AXI channel after ptr, searching 1..4 with 4 wrapping to 1.
  // Returns GRANT_NONE when nothing in 1..4 is requesting.
  function automatic logic [2:0] rr_pick(input logic [4:1] req, input logic [2:0] ptr);
    logic [2:0] pick;
    logic [2:0] cand;
    logic       found;
    pick  = GRANT_NONE;
    cand  = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = (cand == CH_AW) ? CH_B : cand + 3'd1;
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tx_skid_buffer.sv
// Two-entry output buffer with a registered upstream ready.
// Handshake (both sides): a beat transfers on a rising edge where valid and
// ready are both high; valid never waits on ready, and a held beat stays
// stable until it transfers.
module tx_skid_buffer
  import tx_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push      = in_valid && ready_q;
  assign pop       = (count_q != 2'd0) && out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;

  // Occupancy after this cycle's push/pop; drives the registered ready.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  // Head is always the presented beat; tail only holds the second beat while stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= in_data;
          else                 tail_q <= in_data;
        end
        2'b01: head_q <= tail_q;
        2'b11: begin
          if (count_q == 2'd1) head_q <= in_data;
          else begin
            head_q <= tail_q;
            tail_q <= in_data;
          end
        end
        default: ;
      endcase
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
    end
  end

endmodule

// File: rtl/tx_channel_arbiter.sv
// Packet-level merge of the five TX sources: barrier has strict priority, the
// four AXI-derived channels share round-robin, and a grant lasts a whole packet.
module tx_channel_arbiter
  import tx_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 5
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_CH*DATA_WIDTH*8-1:0] ch_data,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_keep,
  input  logic [NUM_CH*CONN_ID_W-1:0]    ch_connection_id,
  input  logic [NUM_CH*BYTE_NUM_W-1:0]   ch_byte_num,
  input  logic [NUM_CH-1:0]              ch_last,
  input  logic [NUM_CH-1:0]              ch_valid,
  output logic [NUM_CH-1:0]              ch_ready,
  output logic [DATA_WIDTH*8-1:0]        tx_data,
  output logic [DATA_WIDTH-1:0]          tx_keep,
  output logic [CONN_ID_W-1:0]           tx_connection_id,
  output logic [BYTE_NUM_W-1:0]          tx_byte_num,
  output logic                           tx_last,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [2:0]                     grant_id,
  output logic                           busy
);

  localparam int PW = DATA_WIDTH * 9 + CONN_ID_W + BYTE_NUM_W + 1;

  arb_state_t    state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    rr_q, rr_d;
  logic [2:0]    sel;
  logic [PW-1:0] sel_payload;
  logic          sel_valid;
  logic          sel_last;
  logic          skid_in_valid;
  logic          skid_in_ready;
  logic          beat_acc;
  logic [PW-1:0] out_payload;

  // Outside a packet grant_q is GRANT_NONE; point the mux somewhere harmless.
  assign sel = (grant_q == GRANT_NONE) ? CH_BARRIER : grant_q;

  // Select the granted channel's beat and pack it for the skid buffer.
  always_comb begin
    sel_payload = '0;
    sel_valid   = 1'b0;
    sel_last    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == 3'(i)) begin
        sel_payload = {ch_data[i*DATA_WIDTH*8 +: DATA_WIDTH*8],
                       ch_keep[i*DATA_WIDTH +: DATA_WIDTH],
                       ch_connection_id[i*CONN_ID_W +: CONN_ID_W],
                       ch_byte_num[i*BYTE_NUM_W +: BYTE_NUM_W],
                       ch_last[i]};
        sel_valid   = ch_valid[i];
        sel_last    = ch_last[i];
      end
    end
  end

  assign skid_in_valid = (state_q == ST_BUSY) && sel_valid;
  assign beat_acc      = skid_in_valid && skid_in_ready;

  // Arbitrate in IDLE; in BUSY forward the granted channel until its last beat.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    ch_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (ch_valid[CH_BARRIER]) begin
          grant_d = CH_BARRIER;
          state_d = ST_BUSY;
        end else if (|ch_valid[4:1]) begin
          grant_d = rr_pick(ch_valid[4:1], rr_q);
          rr_d    = grant_d;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        ch_ready[sel] = skid_in_ready;
        if (beat_acc && sel_last) begin
          state_d = ST_IDLE;
          grant_d = GRANT_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant and round-robin pointer; reset drops any partial packet.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_NONE;
      rr_q    <= CH_AW;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == ST_BUSY);

  tx_skid_buffer #(
    .WIDTH (PW)
  ) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (sel_payload),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .out_data  (out_payload),
    .out_valid (tx_valid),
    .out_ready (tx_ready)
  );

  assign {tx_data, tx_keep, tx_connection_id, tx_byte_num, tx_last} = out_payload;

endmodule

// File: tb/tb_tx_channel_arbiter.sv
// Directed bench for tx_channel_arbiter with per-channel packet sources and an
// in-order scoreboard of expected merged beats.
module tb_tx_channel_arbiter;
  import tx_arb_pkg::*;

  localparam int DW  = 16;
  localparam int NCH = 5;
  localparam int BW  = DW * 8;
  localparam int PW  = DW * 9 + 18;

  typedef struct packed {
    logic [BW-1:0] data;
    logic [DW-1:0] keep;
    logic [3:0]    conn;
    logic [12:0]   bn;
    logic          last;
  } beat_t;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               resetn;
  logic [NCH*BW-1:0]  ch_data;
  logic [NCH*DW-1:0]  ch_keep;
  logic [NCH*4-1:0]   ch_connection_id;
  logic [NCH*13-1:0]  ch_byte_num;
  logic [NCH-1:0]     ch_last;
  logic [NCH-1:0]     ch_valid;
  logic [NCH-1:0]     ch_ready;
  logic [BW-1:0]      tx_data;
  logic [DW-1:0]      tx_keep;
  logic [3:0]         tx_connection_id;
  logic [12:0]        tx_byte_num;
  logic               tx_last;
  logic               tx_valid;
  logic               tx_ready;
  logic [2:0]         grant_id;
  logic               busy;

  always #5 clk = ~clk;

  tx_channel_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .ch_data          (ch_data),
    .ch_keep          (ch_keep),
    .ch_connection_id (ch_connection_id),
    .ch_byte_num      (ch_byte_num),
    .ch_last          (ch_last),
    .ch_valid         (ch_valid),
    .ch_ready         (ch_ready),
    .tx_data          (tx_data),
    .tx_keep          (tx_keep),
    .tx_connection_id (tx_connection_id),
    .tx_byte_num      (tx_byte_num),
    .tx_last          (tx_last),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  // ---------------- scoreboard state ----------------
  logic [PW-1:0] exp_q[$];
  beat_t         src_mem[NCH][64];
  int            src_head[NCH];
  int            src_tail[NCH];
  int            exp_ptr[NCH];
  int            acc_cnt[NCH];
  int            fire_cyc[$];
  int            cyc;
  int            n_cmp;
  int            n_fail;
  logic          hold_pend;
  logic [PW-1:0] hold_val;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_pkt(input int ch, input int nbeats, input logic [3:0] conn, input logic [12:0] bn);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.keep = 16'($urandom);
      b.conn = conn;
      b.bn   = bn;
      b.last = (i == nbeats - 1);
      src_mem[ch][src_tail[ch]] = b;
      src_tail[ch]++;
    end
  endtask

  // Append the next not-yet-expected packet of channel ch to the scoreboard.
  task automatic expect_pkt(input int ch);
    beat_t b;
    b.last = 1'b0;
    while (!b.last && exp_ptr[ch] < src_tail[ch]) begin
      b = src_mem[ch][exp_ptr[ch]];
      exp_q.push_back(b);
      exp_ptr[ch]++;
    end
  endtask

  function automatic logic sources_pending();
    logic p;
    p = 1'b0;
    for (int c = 0; c < NCH; c++) if (src_head[c] < src_tail[c]) p = 1'b1;
    return p;
  endfunction

  // One cycle, entered and left at a falling edge.
  task automatic step(input logic rdy);
    logic [NCH*BW-1:0] d;
    logic [NCH*DW-1:0] k;
    logic [NCH*4-1:0]  cid;
    logic [NCH*13-1:0] bn;
    logic [NCH-1:0]    l, v, acc;
    logic [PW-1:0]     obs;
    beat_t             b;
    d = '0; k = '0; cid = '0; bn = '0; l = '0; v = '0;
    for (int c = 0; c < NCH; c++) begin
      if (src_head[c] < src_tail[c]) begin
        b = src_mem[c][src_head[c]];
        d[c*BW +: BW]  = b.data;
        k[c*DW +: DW]  = b.keep;
        cid[c*4 +: 4]  = b.conn;
        bn[c*13 +: 13] = b.bn;
        l[c]           = b.last;
        v[c]           = 1'b1;
      end
    end
    ch_data = d; ch_keep = k; ch_connection_id = cid; ch_byte_num = bn;
    ch_last = l; ch_valid = v; tx_ready = rdy;
    #1;
    acc = ch_valid & ch_ready;
    obs = {tx_data, tx_keep, tx_connection_id, tx_byte_num, tx_last};
    if (hold_pend) begin
      check("hold_valid", PW'(tx_valid), PW'(1));
      check("hold_fields", obs, hold_val);
    end
    if (tx_valid && tx_ready) begin
      check("beat_expected", PW'(exp_q.size() > 0), PW'(1));
      if (exp_q.size() > 0) check("beat", obs, exp_q.pop_front());
      fire_cyc.push_back(cyc);
    end
    hold_pend = tx_valid && !tx_ready;
    hold_val  = obs;
    @(posedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (acc[c]) begin
        src_head[c]++;
        acc_cnt[c]++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until(input int ch, input int target, input int budget);
    int n;
    n = 0;
    while (acc_cnt[ch] < target && n < budget) begin
      step(1'b1);
      n++;
    end
    check("wait_accept", PW'(acc_cnt[ch] >= target), PW'(1));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || sources_pending()) && n < budget) begin
      step(1'b1);
      n++;
    end
    check("drain_done", PW'(exp_q.size()), PW'(0));
    repeat (3) step(1'b1);
  endtask

  task automatic check_gaps(input string tag, input int nexp);
    check({tag, "_count"}, PW'(fire_cyc.size()), PW'(nexp));
    for (int i = 1; i < fire_cyc.size(); i++)
      check({tag, "_gap"}, PW'(fire_cyc[i] - fire_cyc[i-1]), PW'(2));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k0;
    n_cmp = 0; n_fail = 0; cyc = 0; hold_pend = 1'b0; hold_val = '0;
    for (int c = 0; c < NCH; c++) begin
      src_head[c] = 0; src_tail[c] = 0; exp_ptr[c] = 0; acc_cnt[c] = 0;
    end
    resetn = 1'b0;
    ch_data = '0; ch_keep = '0; ch_connection_id = '0; ch_byte_num = '0;
    ch_last = '0; ch_valid = '0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset values.
    check("rst_tx_valid", PW'(tx_valid), PW'(0));
    check("rst_busy", PW'(busy), PW'(0));
    check("rst_grant", PW'(grant_id), PW'(7));
    check("rst_ch_ready", PW'(ch_ready), PW'(0));
    check("rst_fields", {tx_data, tx_keep, tx_connection_id, tx_byte_num, tx_last}, PW'(0));
    resetn = 1'b1;
    step(1'b1);

    // Single 3-beat AR packet: seen at edge k, beats out on cycles k+2..k+4.
    add_pkt(CH_AR, 3, 4'd5, 13'd48);
    expect_pkt(CH_AR);
    fire_cyc.delete();
    k0 = cyc;
    step(1'b1);
    check("ar_grant", PW'(grant_id), PW'(CH_AR));
    check("ar_busy", PW'(busy), PW'(1));
    check("ar_ch_ready", PW'(ch_ready), PW'(5'b01000));
    drain(40);
    check("ar_beats", PW'(fire_cyc.size()), PW'(3));
    check("ar_first_cycle", PW'(fire_cyc[0]), PW'(k0 + 2));
    check("ar_last_cycle", PW'(fire_cyc[2]), PW'(k0 + 4));

    // Reset during beat 2 of a 5-beat B packet drops the packet.
    add_pkt(CH_B, 5, 4'd9, 13'd80);
    expect_pkt(CH_B);
    run_until(CH_B, acc_cnt[CH_B] + 2, 20);
    resetn = 1'b0;
    #1;
    check("mid_rst_tx_valid", PW'(tx_valid), PW'(0));
    check("mid_rst_busy", PW'(busy), PW'(0));
    check("mid_rst_grant", PW'(grant_id), PW'(7));
    check("mid_rst_ch_ready", PW'(ch_ready), PW'(0));
    for (int c = 0; c < NCH; c++) begin
      src_head[c] = src_tail[c];
      exp_ptr[c]  = src_tail[c];
    end
    exp_q.delete();
    hold_pend = 1'b0;
    step(1'b1);
    step(1'b1);
    resetn = 1'b1;
    // Pointer back at 4: B beats AR even though both request together.
    add_pkt(CH_AR, 2, 4'd3, 13'd32);
    add_pkt(CH_B, 1, 4'd1, 13'd16);
    expect_pkt(CH_B);
    expect_pkt(CH_AR);
    drain(40);

    // Round-robin with all four AXI channels busy; last grant was AR, so AW leads.
    for (int r = 0; r < 2; r++)
      for (int c = 1; c <= 4; c++)
        add_pkt(c, 1, 4'($urandom_range(0, 15)), 13'($urandom_range(1, 4096)));
    for (int r = 0; r < 2; r++) begin
      expect_pkt(CH_AW); expect_pkt(CH_B); expect_pkt(CH_R); expect_pkt(CH_AR);
    end
    fire_cyc.delete();
    drain(60);
    check_gaps("rr", 8);

    // Barrier arrives mid AW packet: no preemption, then barrier, then B, R.
    add_pkt(CH_AW, 8, 4'd7, 13'd128);
    expect_pkt(CH_AW);
    run_until(CH_AW, acc_cnt[CH_AW] + 2, 20);
    add_pkt(CH_BARRIER, 2, 4'd0, 13'd32);
    add_pkt(CH_B, 1, 4'd2, 13'd16);
    add_pkt(CH_R, 1, 4'd4, 13'd16);
    expect_pkt(CH_BARRIER); expect_pkt(CH_B); expect_pkt(CH_R);
    step(1'b1);
    check("bar_no_preempt", PW'(grant_id), PW'(CH_AW));
    drain(60);

    // All five request together: barrier first, then search from R+1.
    for (int c = 0; c < NCH; c++)
      add_pkt(c, 1, 4'($urandom_range(0, 15)), 13'($urandom_range(1, 4096)));
    expect_pkt(CH_BARRIER); expect_pkt(CH_AR); expect_pkt(CH_AW);
    expect_pkt(CH_B); expect_pkt(CH_R);
    drain(60);

    // Backpressure on a 4-beat R packet: tx_ready 1,0,0,1 once beats emerge.
    add_pkt(CH_R, 4, 4'd6, 13'd64);
    expect_pkt(CH_R);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check("bp_ready_one_buffered", PW'(ch_ready[CH_R]), PW'(1));
    step(1'b0);
    check("bp_ready_two_buffered", PW'(ch_ready[CH_R]), PW'(0));
    check("bp_tx_valid_held", PW'(tx_valid), PW'(1));
    step(1'b0);
    drain(40);

    // Only R requesting: granted every packet with one idle input cycle between.
    for (int r = 0; r < 3; r++) begin
      add_pkt(CH_R, 1, 4'($urandom_range(0, 15)), 13'($urandom_range(1, 4096)));
      expect_pkt(CH_R);
    end
    fire_cyc.delete();
    drain(40);
    check_gaps("idle_r", 3);
    // Pointer still at R, so AR wins over B.
    add_pkt(CH_B, 1, 4'd8, 13'd16);
    add_pkt(CH_AR, 1, 4'd10, 13'd16);
    expect_pkt(CH_AR);
    expect_pkt(CH_B);
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
